// File: rtl/cnn_pkg.sv
// cnn_pkg: shared types and helpers for the CNN datapath blocks.
//   pool_state_t     - pooling sequencer FSM states
//   addr_width       - bit width needed to address 'depth' words (min 1)
//   conv_addr_width  - flat convolution buffer address width
//   pool_addr_width  - flat pooled buffer address width
package cnn_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    READ  = 2'd1,
    DRAIN = 2'd2,
    DONE  = 2'd3
  } pool_state_t;

  function automatic int unsigned addr_width(input int unsigned depth);
    return (depth <= 1) ? 1 : $clog2(depth);
  endfunction

  function automatic int unsigned conv_addr_width(input int unsigned features,
                                                  input int unsigned height,
                                                  input int unsigned width);
    return addr_width(features * height * width);
  endfunction

  function automatic int unsigned pool_addr_width(input int unsigned features,
                                                  input int unsigned height,
                                                  input int unsigned width);
    return addr_width(features * height * width);
  endfunction

endpackage

// File: rtl/pool_sequencer_max_accum.sv
// pool_max_accum: signed running-maximum register for one pooling tile.
// Optional feature macro: POOL_RELU_EN (seed the tile maximum with 0 so the
// pooled value becomes max(0, tile max)); undefined = pure signed max.
// Ports:
//   clk, reset          - clock, synchronous active-high reset
//   in_valid            - data is a tile element this cycle
//   first, last         - element is the first / last of its tile
//   data                - signed element value
//   out_valid, out_data - registered tile maximum, valid one cycle after 'last'
module pool_max_accum #(
  parameter int unsigned DATA_WIDTH = 8
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         in_valid,
  input  logic                         first,
  input  logic                         last,
  input  logic signed [DATA_WIDTH-1:0] data,
  output logic                         out_valid,
  output logic signed [DATA_WIDTH-1:0] out_data
);

  logic signed [DATA_WIDTH-1:0] acc;
  logic signed [DATA_WIDTH-1:0] base;
  logic signed [DATA_WIDTH-1:0] acc_next;

  always_comb begin
`ifdef POOL_RELU_EN
    base = first ? '0 : acc;
`else
    base = first ? data : acc;
`endif
    acc_next = (data > base) ? data : base;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      acc       <= '0;
      out_valid <= 1'b0;
      out_data  <= '0;
    end else begin
      out_valid <= in_valid && last;
      if (in_valid) begin
        acc <= acc_next;
        if (last) begin
          out_data <= acc_next;
        end
      end
    end
  end

endmodule

// File: rtl/pool_sequencer.sv
// pool_sequencer: sequential max-pooling engine. On start it reads every
// feature map in POOLING_STRIDE x POOLING_STRIDE tiles (one read per clock),
// keeps a signed running max per tile and writes one pooled word per tile,
// then pulses done.
// Optional feature macro: POOL_RELU_EN (handled in pool_max_accum).
// Ports:
//   clk, reset    - clock, synchronous active-high reset
//   start         - begin a pass (sampled only in IDLE)
//   busy, done    - pass in progress / one-cycle end-of-pass pulse
//   conv_rd_en, conv_rd_addr, conv_rd_data - convolution buffer read port
//                   (data returns one cycle after the strobe)
//   pool_wr_en, pool_wr_addr, pool_wr_data - pooled buffer write port
module pool_sequencer
  import cnn_pkg::*;
#(
  parameter int unsigned NUM_FEATURES       = 3,
  parameter int unsigned POOLING_STRIDE     = 2,
  parameter int unsigned CONVOLUTION_HEIGHT = 25,
  parameter int unsigned CONVOLUTION_WIDTH  = 25,
  parameter int unsigned POOLED_HEIGHT      = 12,
  parameter int unsigned POOLED_WIDTH       = 12,
  parameter int unsigned DATA_WIDTH         = 8,
  localparam int unsigned CONV_AW = conv_addr_width(NUM_FEATURES, CONVOLUTION_HEIGHT, CONVOLUTION_WIDTH),
  localparam int unsigned POOL_AW = pool_addr_width(NUM_FEATURES, POOLED_HEIGHT, POOLED_WIDTH)
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         start,
  output logic                         busy,
  output logic                         done,
  output logic                         conv_rd_en,
  output logic [CONV_AW-1:0]           conv_rd_addr,
  input  logic signed [DATA_WIDTH-1:0] conv_rd_data,
  output logic                         pool_wr_en,
  output logic [POOL_AW-1:0]           pool_wr_addr,
  output logic signed [DATA_WIDTH-1:0] pool_wr_data
);

  localparam int unsigned FW = addr_width(NUM_FEATURES);
  localparam int unsigned RW = addr_width(POOLED_HEIGHT);
  localparam int unsigned CW = addr_width(POOLED_WIDTH);
  localparam int unsigned SW = addr_width(POOLING_STRIDE);

  pool_state_t state, state_next;
  logic        drain_cnt;

  // Tile walk counters, outermost to innermost: f, r, c, pr, pc.
  logic [FW-1:0] f;
  logic [RW-1:0] r;
  logic [CW-1:0] c;
  logic [SW-1:0] pr;
  logic [SW-1:0] pc;

  logic tile_first;
  logic tile_last;
  logic pass_last;

  // Read-side pipeline: tile flags travel with the strobe so they line up
  // with conv_rd_data one cycle later.
  logic rd_valid_q;
  logic first_q;
  logic last_q;

  logic                         acc_valid;
  logic signed [DATA_WIDTH-1:0] acc_data;
  logic [POOL_AW-1:0]           wr_cnt;

  always_comb begin
    tile_first = (pr == '0) && (pc == '0);
    tile_last  = (pr == SW'(POOLING_STRIDE - 1)) && (pc == SW'(POOLING_STRIDE - 1));
    pass_last  = tile_last
              && (c == CW'(POOLED_WIDTH - 1))
              && (r == RW'(POOLED_HEIGHT - 1))
              && (f == FW'(NUM_FEATURES - 1));
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= IDLE;
      drain_cnt <= 1'b0;
    end else begin
      state     <= state_next;
      drain_cnt <= (state == DRAIN) ? ~drain_cnt : 1'b0;
    end
  end

  always_comb begin
    state_next = state;
    conv_rd_en = 1'b0;
    busy       = 1'b0;
    done       = 1'b0;
    case (state)
      IDLE: begin
        if (start) begin
          state_next = READ;
        end
      end
      READ: begin
        conv_rd_en = 1'b1;
        busy       = 1'b1;
        if (pass_last) begin
          state_next = DRAIN;
        end
      end
      DRAIN: begin
        busy = 1'b1;
        if (drain_cnt) begin
          state_next = DONE;
        end
      end
      DONE: begin
        done       = 1'b1;
        state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset || (state != READ)) begin
      f  <= '0;
      r  <= '0;
      c  <= '0;
      pr <= '0;
      pc <= '0;
    end else if (pc != SW'(POOLING_STRIDE - 1)) begin
      pc <= pc + SW'(1);
    end else begin
      pc <= '0;
      if (pr != SW'(POOLING_STRIDE - 1)) begin
        pr <= pr + SW'(1);
      end else begin
        pr <= '0;
        if (c != CW'(POOLED_WIDTH - 1)) begin
          c <= c + CW'(1);
        end else begin
          c <= '0;
          if (r != RW'(POOLED_HEIGHT - 1)) begin
            r <= r + RW'(1);
          end else begin
            r <= '0;
            if (f != FW'(NUM_FEATURES - 1)) begin
              f <= f + FW'(1);
            end else begin
              f <= '0;
            end
          end
        end
      end
    end
  end

  // Flat address; rows/cols beyond POOLED*STRIDE are never generated.
  always_comb begin
    conv_rd_addr = '0;
    if (conv_rd_en) begin
      conv_rd_addr = CONV_AW'(f) * CONV_AW'(CONVOLUTION_HEIGHT * CONVOLUTION_WIDTH)
                   + (CONV_AW'(r) * CONV_AW'(POOLING_STRIDE) + CONV_AW'(pr)) * CONV_AW'(CONVOLUTION_WIDTH)
                   + CONV_AW'(c) * CONV_AW'(POOLING_STRIDE) + CONV_AW'(pc);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      rd_valid_q <= 1'b0;
      first_q    <= 1'b0;
      last_q     <= 1'b0;
    end else begin
      rd_valid_q <= conv_rd_en;
      first_q    <= tile_first;
      last_q     <= tile_last;
    end
  end

  pool_max_accum #(
    .DATA_WIDTH (DATA_WIDTH)
  ) u_accum (
    .clk       (clk),
    .reset     (reset),
    .in_valid  (rd_valid_q),
    .first     (first_q),
    .last      (last_q),
    .data      (conv_rd_data),
    .out_valid (acc_valid),
    .out_data  (acc_data)
  );

  // Write addresses are simply sequential because tiles complete in
  // f, r, c order, matching the flat pooled layout.
  always_ff @(posedge clk) begin
    if (reset || (state == DONE)) begin
      wr_cnt <= '0;
    end else if (acc_valid) begin
      wr_cnt <= wr_cnt + POOL_AW'(1);
    end
  end

  always_comb begin
    pool_wr_en   = acc_valid;
    pool_wr_addr = acc_valid ? wr_cnt : '0;
    pool_wr_data = acc_valid ? acc_data : '0;
  end

endmodule

// File: tb/tb_pool_sequencer.sv
// tb_pool_sequencer: self-checking bench for pool_sequencer.
// Three instances: A (F=1, 4x4 -> 2x2), B (F=1, 5x5 -> 2x2, trailing row/col
// dropped) and D (default sizes). D is checked against a scoreboard of
// expected read addresses and pooled writes.
module tb_pool_sequencer;

`ifdef POOL_RELU_EN
  localparam bit RELU = 1'b1;
`else
  localparam bit RELU = 1'b0;
`endif

  localparam int ND = 3 * 12 * 12 * 4;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  logic reset = 1'b1;
  logic start_a = 1'b0, start_b = 1'b0, start_d = 1'b0;

  int checks = 0;
  int errors = 0;

  task automatic chk(input string nm, input logic signed [31:0] act, input logic signed [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%0d required=%0d", nm, act, req);
    end
  endtask

  // ---------------- instance A ----------------
  logic busy_a, done_a, rd_en_a, wr_en_a;
  logic [3:0] rd_addr_a;
  logic [1:0] wr_addr_a;
  logic signed [7:0] rd_data_a, wr_data_a;
  logic signed [7:0] mem_a [16];

  pool_sequencer #(
    .NUM_FEATURES(1), .POOLING_STRIDE(2), .CONVOLUTION_HEIGHT(4), .CONVOLUTION_WIDTH(4),
    .POOLED_HEIGHT(2), .POOLED_WIDTH(2), .DATA_WIDTH(8)
  ) u_a (
    .clk(clk), .reset(reset), .start(start_a), .busy(busy_a), .done(done_a),
    .conv_rd_en(rd_en_a), .conv_rd_addr(rd_addr_a), .conv_rd_data(rd_data_a),
    .pool_wr_en(wr_en_a), .pool_wr_addr(wr_addr_a), .pool_wr_data(wr_data_a)
  );
  always @(posedge clk) rd_data_a <= rd_en_a ? mem_a[rd_addr_a] : 8'($urandom);

  // ---------------- instance B ----------------
  logic busy_b, done_b, rd_en_b, wr_en_b;
  logic [4:0] rd_addr_b;
  logic [1:0] wr_addr_b;
  logic signed [7:0] rd_data_b, wr_data_b;
  logic signed [7:0] mem_b [25];

  pool_sequencer #(
    .NUM_FEATURES(1), .POOLING_STRIDE(2), .CONVOLUTION_HEIGHT(5), .CONVOLUTION_WIDTH(5),
    .POOLED_HEIGHT(2), .POOLED_WIDTH(2), .DATA_WIDTH(8)
  ) u_b (
    .clk(clk), .reset(reset), .start(start_b), .busy(busy_b), .done(done_b),
    .conv_rd_en(rd_en_b), .conv_rd_addr(rd_addr_b), .conv_rd_data(rd_data_b),
    .pool_wr_en(wr_en_b), .pool_wr_addr(wr_addr_b), .pool_wr_data(wr_data_b)
  );
  always @(posedge clk) rd_data_b <= rd_en_b ? mem_b[rd_addr_b] : 8'($urandom);

  // ---------------- instance D (defaults) ----------------
  logic busy_d, done_d, rd_en_d, wr_en_d;
  logic [10:0] rd_addr_d;
  logic [8:0]  wr_addr_d;
  logic signed [7:0] rd_data_d, wr_data_d;
  logic signed [7:0] mem_d [1875];

  pool_sequencer u_d (
    .clk(clk), .reset(reset), .start(start_d), .busy(busy_d), .done(done_d),
    .conv_rd_en(rd_en_d), .conv_rd_addr(rd_addr_d), .conv_rd_data(rd_data_d),
    .pool_wr_en(wr_en_d), .pool_wr_addr(wr_addr_d), .pool_wr_data(wr_data_d)
  );
  always @(posedge clk) rd_data_d <= rd_en_d ? mem_d[rd_addr_d] : 8'($urandom);

  // ---------------- monitors ----------------
  int rd_cnt_a, busy_cnt_a, wr_cnt_a;
  logic signed [7:0] res_a [4];
  int rd_cnt_b, busy_cnt_b, wr_cnt_b, bad_rd_b;
  logic signed [7:0] res_b [4];

  typedef struct { int addr; int data; } wr_exp_t;
  int      rdq[$];
  wr_exp_t wrq[$];
  bit mon_d = 1'b0;
  bit prev_rd_d = 1'b0;
  int rd_cnt_d, rd_runs_d, wr_cnt_d, busy_cnt_d, done_cnt_d;

  initial forever begin
    @(negedge clk);
    if (rd_en_a) rd_cnt_a++;
    if (busy_a) busy_cnt_a++;
    if (wr_en_a) begin
      chk("a_wr_addr_seq", wr_addr_a, wr_cnt_a);
      if (wr_cnt_a < 4) res_a[wr_cnt_a] = wr_data_a;
      wr_cnt_a++;
    end
    if (rd_en_b) begin
      rd_cnt_b++;
      if ((rd_addr_b % 5 == 4) || (rd_addr_b >= 20)) bad_rd_b++;
    end
    if (busy_b) busy_cnt_b++;
    if (wr_en_b) begin
      chk("b_wr_addr_seq", wr_addr_b, wr_cnt_b);
      if (wr_cnt_b < 4) res_b[wr_cnt_b] = wr_data_b;
      wr_cnt_b++;
    end
    if (mon_d) begin
      if (rd_en_d) begin
        rd_cnt_d++;
        if (!prev_rd_d) rd_runs_d++;
        if (rdq.size() > 0) chk("d_rd_addr", rd_addr_d, rdq.pop_front());
      end
      if (wr_en_d) begin
        wr_cnt_d++;
        if (wrq.size() > 0) begin
          wr_exp_t w;
          w = wrq.pop_front();
          chk("d_wr_addr", wr_addr_d, w.addr);
          chk("d_wr_data", wr_data_d, w.data);
        end
      end
      if (busy_d) busy_cnt_d++;
      if (done_d) done_cnt_d++;
    end
    prev_rd_d = rd_en_d;
  end

  // ---------------- pass drivers ----------------
  task automatic pass_a(output int rel);
    int t0;
    rel = -1; rd_cnt_a = 0; busy_cnt_a = 0; wr_cnt_a = 0;
    @(negedge clk); t0 = cyc; start_a = 1'b1;
    @(negedge clk); start_a = 1'b0;
    for (int i = 0; i < 60; i++) begin
      if (done_a) begin rel = cyc - t0; break; end
      @(negedge clk);
    end
    #1;
  endtask

  task automatic pass_b(output int rel);
    int t0;
    rel = -1; rd_cnt_b = 0; busy_cnt_b = 0; wr_cnt_b = 0; bad_rd_b = 0;
    @(negedge clk); t0 = cyc; start_b = 1'b1;
    @(negedge clk); start_b = 1'b0;
    for (int i = 0; i < 60; i++) begin
      if (done_b) begin rel = cyc - t0; break; end
      @(negedge clk);
    end
    #1;
  endtask

  // Fill D's memory and scoreboards for one pass.
  task automatic prepare_d();
    rdq.delete(); wrq.delete();
    foreach (mem_d[i]) mem_d[i] = 8'($urandom);
    for (int f = 0; f < 3; f++)
      for (int r = 0; r < 12; r++)
        for (int c = 0; c < 12; c++) begin
          int m;
          m = 0;
          for (int pr = 0; pr < 2; pr++)
            for (int pc = 0; pc < 2; pc++) begin
              int a, v;
              a = f * 625 + (r * 2 + pr) * 25 + c * 2 + pc;
              v = mem_d[a];
              rdq.push_back(a);
              if ((pr == 0) && (pc == 0) && !RELU) m = v;
              else if (v > m) m = v;
            end
          wrq.push_back('{f * 144 + r * 12 + c, m});
        end
    rd_cnt_d = 0; rd_runs_d = 0; wr_cnt_d = 0; busy_cnt_d = 0; done_cnt_d = 0;
    mon_d = 1'b1;
  endtask

  task automatic pass_d(input bit spam);
    int t0, rel;
    rel = -1;
    @(negedge clk); t0 = cyc; start_d = 1'b1;
    @(negedge clk); start_d = 1'b0;
    for (int i = 0; i < 2000; i++) begin
      if (done_d) begin rel = cyc - t0; break; end
      if (spam && busy_d) start_d = 1'($urandom_range(0, 1));
      @(negedge clk);
    end
    start_d = 1'b0;
    #1;
    chk("d_done_cycle", rel, ND + 3);
    chk("d_rd_cycles", rd_cnt_d, ND);
    chk("d_rd_runs", rd_runs_d, 1);
    chk("d_busy_cycles", busy_cnt_d, ND + 2);
    chk("d_done_count", done_cnt_d, 1);
    chk("d_wr_count", wr_cnt_d, 432);
    chk("d_rdq_left", rdq.size(), 0);
    chk("d_wrq_left", wrq.size(), 0);
  endtask

  task automatic chk_d_idle(input string nm);
    chk({nm, "_busy"}, busy_d, 0);
    chk({nm, "_done"}, done_d, 0);
    chk({nm, "_rd_en"}, rd_en_d, 0);
    chk({nm, "_rd_addr"}, rd_addr_d, 0);
    chk({nm, "_wr_en"}, wr_en_d, 0);
    chk({nm, "_wr_addr"}, wr_addr_d, 0);
    chk({nm, "_wr_data"}, wr_data_d, 0);
  endtask

  // ---------------- vectors for single-tile checks ----------------
  typedef struct {
    string nm;
    logic signed [7:0] v0, v1, v2, v3;
    logic signed [7:0] ex, ex_relu;
  } vec_t;
  vec_t tbl [6];

  initial begin
    #20_000_000;
    $display("FAIL watchdog time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int rel;
    int act;

    tbl[0] = '{"t_ascending",   8'sd1,    8'sd2,   8'sd3,    8'sd4,   8'sd4,   8'sd4};
    tbl[1] = '{"t_all_negative",-8'sd128, -8'sd3,  -8'sd50,  -8'sd7,  -8'sd3,  8'sd0};
    tbl[2] = '{"t_extremes",    8'sd127,  -8'sd128, 8'sd0,   8'sd0,   8'sd127, 8'sd127};
    tbl[3] = '{"t_minus_one",   -8'sd1,   -8'sd1,  -8'sd1,   -8'sd1,  -8'sd1,  8'sd0};
    tbl[4] = '{"t_max_middle",  8'sd5,    8'sd127, -8'sd128, 8'sd126, 8'sd127, 8'sd127};
    tbl[5] = '{"t_neg_first",   -8'sd100, 8'sd20,  8'sd19,   -8'sd2,  8'sd20,  8'sd20};

    // Reset state
    repeat (3) @(negedge clk);
    chk_d_idle("reset_d");
    chk("reset_a_rd_en", rd_en_a, 0);
    chk("reset_a_wr_en", wr_en_a, 0);
    reset = 1'b0;
    repeat (2) @(negedge clk);

    // Ramp 0..15 on A
    foreach (mem_a[i]) mem_a[i] = 8'(i);
    pass_a(rel);
    chk("ramp_done_cycle", rel, 19);
    chk("ramp_rd_cycles", rd_cnt_a, 16);
    chk("ramp_busy_cycles", busy_cnt_a, 18);
    chk("ramp_wr_count", wr_cnt_a, 4);
    chk("ramp_wr0", res_a[0], 5);
    chk("ramp_wr1", res_a[1], 7);
    chk("ramp_wr2", res_a[2], 13);
    chk("ramp_wr3", res_a[3], 15);

    // Table-driven single tiles on A: tile 0 in order, tile 3 reversed
    for (int i = 0; i < 6; i++) begin
      foreach (mem_a[j]) mem_a[j] = -8'sd90;
      mem_a[0] = tbl[i].v0;  mem_a[1] = tbl[i].v1;
      mem_a[4] = tbl[i].v2;  mem_a[5] = tbl[i].v3;
      mem_a[15] = tbl[i].v0; mem_a[14] = tbl[i].v1;
      mem_a[11] = tbl[i].v2; mem_a[10] = tbl[i].v3;
      pass_a(rel);
      chk({tbl[i].nm, "_done"}, rel, 19);
      chk({tbl[i].nm, "_tile0"}, res_a[0], RELU ? tbl[i].ex_relu : tbl[i].ex);
      chk({tbl[i].nm, "_tile3"}, res_a[3], RELU ? tbl[i].ex_relu : tbl[i].ex);
    end

    // Trailing row/col never read on B
    for (int i = 0; i < 25; i++) mem_b[i] = ((i % 5 == 4) || (i >= 20)) ? 8'sd127 : 8'sd1;
    pass_b(rel);
    chk("trail_done_cycle", rel, 19);
    chk("trail_bad_reads", bad_rd_b, 0);
    chk("trail_rd_cycles", rd_cnt_b, 16);
    chk("trail_busy_cycles", busy_cnt_b, 18);
    chk("trail_wr_count", wr_cnt_b, 4);
    for (int i = 0; i < 4; i++) chk("trail_wr_data", res_b[i], 1);

    // Full default pass on D
    prepare_d();
    pass_d(1'b0);

    // Reset in cycle 10 of a pass
    prepare_d();
    @(negedge clk); start_d = 1'b1;
    @(negedge clk); start_d = 1'b0;
    repeat (9) @(negedge clk);
    reset = 1'b1;
    mon_d = 1'b0;
    @(negedge clk);
    chk_d_idle("midreset");
    reset = 1'b0;
    act = 0;
    repeat (20) begin
      @(negedge clk);
      if (rd_en_d || wr_en_d || busy_d || done_d) act++;
    end
    chk("midreset_activity", act, 0);

    // Fresh pass after reset, with start pulsed while busy
    prepare_d();
    pass_d(1'b1);

    // Back-to-back: start in the cycle after done, same data
    begin
      logic signed [7:0] keep [1875];
      keep = mem_d;
      prepare_d();
      mem_d = keep;
    end
    rdq.delete(); wrq.delete();
    for (int f = 0; f < 3; f++)
      for (int r = 0; r < 12; r++)
        for (int c = 0; c < 12; c++) begin
          int m;
          m = 0;
          for (int pr = 0; pr < 2; pr++)
            for (int pc = 0; pc < 2; pc++) begin
              int a, v;
              a = f * 625 + (r * 2 + pr) * 25 + c * 2 + pc;
              v = mem_d[a];
              rdq.push_back(a);
              if ((pr == 0) && (pc == 0) && !RELU) m = v;
              else if (v > m) m = v;
            end
          wrq.push_back('{f * 144 + r * 12 + c, m});
        end
    pass_d(1'b0);
    // Queue for the repeat pass, launched the cycle after done
    for (int f = 0; f < 3; f++)
      for (int r = 0; r < 12; r++)
        for (int c = 0; c < 12; c++) begin
          int m;
          m = 0;
          for (int pr = 0; pr < 2; pr++)
            for (int pc = 0; pc < 2; pc++) begin
              int a, v;
              a = f * 625 + (r * 2 + pr) * 25 + c * 2 + pc;
              v = mem_d[a];
              rdq.push_back(a);
              if ((pr == 0) && (pc == 0) && !RELU) m = v;
              else if (v > m) m = v;
            end
          wrq.push_back('{f * 144 + r * 12 + c, m});
        end
    rd_cnt_d = 0; rd_runs_d = 0; wr_cnt_d = 0; busy_cnt_d = 0; done_cnt_d = 0;
    pass_d(1'b0);

    mon_d = 1'b0;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
